frame_scheduler: RTL and testbench
==================================

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 The block SHALL have parameter FRAME_CYCLES, default 1_000_000, giving clk cycles per frame period (minimum 16).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 65_535, giving the maximum wait per stage before abort (minimum 2).
REQ-003 Port clk, input, 1: the single system clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port run, input, 1: level; 1 = free-running frames, 0 = paused.
REQ-006 Port step, input, 1: single-cycle pulse; requests exactly one frame while paused.
REQ-007 Port imu_start, output, 1: one-cycle pulse requesting an IMU sample.
REQ-008 Port imu_done, input, 1: one-cycle pulse; IMU sample is valid.
REQ-009 Port phys_start, output, 1: one-cycle pulse requesting one physics update.
REQ-010 Port phys_done, input, 1: one-cycle pulse; physics update is complete.
REQ-011 Port led_start, output, 1: one-cycle pulse requesting an LED matrix refresh.
REQ-012 Port led_done, input, 1: one-cycle pulse; LED refresh is complete.
REQ-013 Port frame_count, output, 16: number of completed frames, wrapping modulo 2^16.
REQ-014 Port timeout_err, output, 1: sticky flag; a stage exceeded TIMEOUT_CYCLES.
REQ-015 Port busy, output, 1: high in every state except IDLE.

Function
REQ-016 The FSM SHALL have exactly these states: IDLE, IMU_WAIT, PHYS_WAIT, LED_WAIT, HOLD.
REQ-017 Period counter: counts clk cycles from the cycle the frame starts and saturates at FRAME_CYCLES-1.
REQ-018 Frame start from IDLE: when run=1, or when run=0 and step=1, the FSM SHALL pulse imu_start in that cycle, clear the period and timeout counters, and enter IMU_WAIT.
REQ-019 IMU_WAIT: on imu_done, pulse phys_start in the same cycle, clear the timeout counter, and enter PHYS_WAIT.
REQ-020 PHYS_WAIT: on phys_done, pulse led_start in the same cycle, clear the timeout counter, and enter LED_WAIT.
REQ-021 LED_WAIT: on led_done, increment frame_count and enter HOLD.
REQ-022 HOLD: the FSM SHALL stay in HOLD until the period counter reaches FRAME_CYCLES-1.
- If run=1 at that point, the FSM SHALL start the next frame directly, as in REQ-018, with no IDLE cycle.
- Otherwise the FSM SHALL enter IDLE.
REQ-023 Frame period: in free-run, consecutive imu_start pulses SHALL be exactly FRAME_CYCLES cycles apart when all stages complete in time.
REQ-024 Overrun: if the stages take longer than FRAME_CYCLES, the next frame SHALL start the cycle after HOLD is entered; no frame is skipped.
REQ-025 Timeout: in each *_WAIT state the timeout counter increments every cycle. If it reaches TIMEOUT_CYCLES-1 without the matching done, the FSM SHALL:
- set timeout_err;
- leave frame_count unchanged;
- enter HOLD, keeping the period timing.
REQ-026 Unexpected done pulses (wrong state, or a done for another stage) SHALL be ignored.
REQ-027 A done arriving in the same cycle as the timeout limit SHALL be treated as success.
REQ-028 step pulses received while busy=1 SHALL be ignored; step is not queued.
REQ-029 Deasserting run mid-frame SHALL let the current frame complete through HOLD, then enter IDLE.
REQ-030 At most one of imu_start, phys_start, led_start SHALL be high in any cycle.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 While reset=1 at a clock edge, the block SHALL enter IDLE and zero:
- imu_start, phys_start, led_start;
- frame_count, timeout_err, busy;
- the period and timeout counters.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately with no further start pulses; done pulses during reset SHALL be ignored.
REQ-034 The first frame after reset deasserts SHALL start only on run or step, per REQ-018.
REQ-035 timeout_err SHALL clear only on reset.

Verification
REQ-036 Bench parameters FRAME_CYCLES=32, TIMEOUT_CYCLES=8. run=1, each done returned 2 cycles after its start -> imu_start pulses 32 cycles apart; sequence imu->phys->led; frame_count 0,1,2,...
REQ-037 run=0, single step pulse -> exactly one frame, frame_count=1, busy low 32 cycles after imu_start; a second step sent while busy -> no extra frame.
REQ-038 phys_done withheld -> timeout_err=1 at 8 cycles after phys_start; no led_start; frame_count unchanged; next imu_start still 32 cycles after the previous one.
REQ-039 Overrun: led_done returned 40 cycles after led_start -> next imu_start exactly 1 cycle after led_done; frame_count increments.
REQ-040 Reset asserted in PHYS_WAIT -> next cycle all outputs 0, state IDLE; a late phys_done is ignored.
REQ-041 Wrap-around: preload the count near the top (or run 65_536 frames) -> frame_count goes 0xFFFF -> 0x0000; stray done pulses in IDLE produce no start pulses.

Source files
------------

// File: rtl/frame_scheduler.sv
// Frame sequencer: IMU sample -> physics update -> LED refresh, once per frame
// period, with per-stage timeout, free-run / single-step control and a frame counter.
module frame_scheduler #(
  parameter int unsigned FRAME_CYCLES   = 1_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 65_535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  output logic        imu_start,
  input  logic        imu_done,
  output logic        phys_start,
  input  logic        phys_done,
  output logic        led_start,
  input  logic        led_done,
  output logic [15:0] frame_count,
  output logic        timeout_err,
  output logic        busy
);

  // Counters only need to reach N-1, which always fits in clog2(N) bits.
  localparam int unsigned PERIOD_W  = $clog2(FRAME_CYCLES);
  localparam int unsigned TIMEOUT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [PERIOD_W-1:0]  PERIOD_LAST  = PERIOD_W'(FRAME_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    IMU_WAIT,
    PHYS_WAIT,
    LED_WAIT,
    HOLD
  } state_t;

  state_t                 state;
  logic [PERIOD_W-1:0]    period_cnt;
  logic [TIMEOUT_W-1:0]   timeout_cnt;
  logic                   period_end;
  logic                   timeout_hit;
  logic                   start_frame;

  // Frame boundary reached, stage wait limit reached, and new-frame decision.
  assign period_end  = (period_cnt == PERIOD_LAST);
  assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);
  assign start_frame = ((state == IDLE) && (run || step)) ||
                       ((state == HOLD) && period_end && run);

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      imu_start   <= 1'b0;
      phys_start  <= 1'b0;
      led_start   <= 1'b0;
      frame_count <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      period_cnt  <= '0;
      timeout_cnt <= '0;
    end else begin
      imu_start  <= 1'b0;
      phys_start <= 1'b0;
      led_start  <= 1'b0;
      if (!period_end) begin
        period_cnt <= period_cnt + PERIOD_W'(1);
      end

      if (start_frame) begin
        // Shared by IDLE and HOLD so back-to-back frames need no IDLE cycle.
        imu_start   <= 1'b1;
        period_cnt  <= '0;
        timeout_cnt <= '0;
        busy        <= 1'b1;
        state       <= IMU_WAIT;
      end else begin
        // A done in the limit cycle wins over the timeout.
        case (state)
          IMU_WAIT: begin
            if (imu_done) begin
              phys_start  <= 1'b1;
              timeout_cnt <= '0;
              state       <= PHYS_WAIT;
            end else if (timeout_hit) begin
              timeout_err <= 1'b1;
              state       <= HOLD;
            end else begin
              timeout_cnt <= timeout_cnt + TIMEOUT_W'(1);
            end
          end
          PHYS_WAIT: begin
            if (phys_done) begin
              led_start   <= 1'b1;
              timeout_cnt <= '0;
              state       <= LED_WAIT;
            end else if (timeout_hit) begin
              timeout_err <= 1'b1;
              state       <= HOLD;
            end else begin
              timeout_cnt <= timeout_cnt + TIMEOUT_W'(1);
            end
          end
          LED_WAIT: begin
            if (led_done) begin
              frame_count <= frame_count + 16'd1;
              state       <= HOLD;
            end else if (timeout_hit) begin
              timeout_err <= 1'b1;
              state       <= HOLD;
            end else begin
              timeout_cnt <= timeout_cnt + TIMEOUT_W'(1);
            end
          end
          HOLD: begin
            if (period_end) begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          IDLE: begin
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench for frame_scheduler: event-time reference model,
// randomized stage latencies and stray done pulses.
module tb_frame_scheduler;

  localparam int unsigned FC  = 32;
  localparam int unsigned TO  = 8;
  localparam int unsigned TO2 = 64;
  localparam int NF = 10;

  logic        clk = 1'b0;
  logic        reset, run, step, imu_done, phys_done, led_done;
  logic        imu_start, phys_start, led_start, timeout_err, busy;
  logic [15:0] frame_count;

  logic        run2, step2, imu_done2, phys_done2, led_done2;
  logic        imu_start2, phys_start2, led_start2, timeout_err2, busy2;
  logic [15:0] frame_count2;

  logic [20:0] obs, obs2;
  assign obs  = {imu_start, phys_start, led_start, busy, timeout_err, frame_count};
  assign obs2 = {imu_start2, phys_start2, led_start2, busy2, timeout_err2, frame_count2};

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_fc;
  logic        exp_to;

  always #5 clk = ~clk;

  frame_scheduler #(.FRAME_CYCLES(FC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .imu_start(imu_start), .imu_done(imu_done),
    .phys_start(phys_start), .phys_done(phys_done),
    .led_start(led_start), .led_done(led_done),
    .frame_count(frame_count), .timeout_err(timeout_err), .busy(busy)
  );

  // Long stage limit so a frame can overrun its period without timing out.
  frame_scheduler #(.FRAME_CYCLES(FC), .TIMEOUT_CYCLES(TO2)) dut_ovr (
    .clk(clk), .reset(reset), .run(run2), .step(step2),
    .imu_start(imu_start2), .imu_done(imu_done2),
    .phys_start(phys_start2), .phys_done(phys_done2),
    .led_start(led_start2), .led_done(led_done2),
    .frame_count(frame_count2), .timeout_err(timeout_err2), .busy(busy2)
  );

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; step = 1'b0;
    imu_done = 1'b0; phys_done = 1'b0; led_done = 1'b0;
    run2 = 1'b0; step2 = 1'b0; imu_done2 = 1'b0; phys_done2 = 1'b0; led_done2 = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (obs !== 21'd0) begin n_fail++; $display("FAIL reset_state got=%h exp=%h", obs, 21'd0); end
    n_tests++;
    if (obs2 !== 21'd0) begin n_fail++; $display("FAIL reset_state_ovr got=%h exp=%h", obs2, 21'd0); end
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      imu_done = k[0]; phys_done = ~k[0]; led_done = (k == 3);
      @(negedge clk);
      n_tests++;
      if (obs !== 21'd0) begin n_fail++; $display("FAIL idle_after_reset k=%0d got=%h exp=%h", k, obs, 21'd0); end
    end
    imu_done = 1'b0; phys_done = 1'b0; led_done = 1'b0;
    exp_fc = 16'd0; exp_to = 1'b0;
  endtask

  // One step-triggered frame, every done 2 cycles after its start; steps while busy ignored.
  task automatic test_step();
    logic [20:0] exp;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    for (int k = 0; k <= int'(FC) + 3; k++) begin
      exp = {k == 0, k == 2, k == 4, k < int'(FC), exp_to,
             (k >= 6) ? 16'(exp_fc + 16'd1) : exp_fc};
      n_tests++;
      if (obs !== exp) begin n_fail++; $display("FAIL step_frame k=%0d got=%h exp=%h", k, obs, exp); end
      imu_done  = (k == 1);
      phys_done = (k == 3);
      led_done  = (k == 5);
      step      = (k == 7) || (k == int'(FC) - 1);
      @(negedge clk);
    end
    step = 1'b0; imu_done = 1'b0; phys_done = 1'b0; led_done = 1'b0;
    exp_fc = 16'(exp_fc + 16'd1);
  endtask

  // Physics withheld -> sticky timeout, period kept; then reset in PHYS_WAIT.
  task automatic test_timeout_reset();
    logic [20:0] exp;
    run = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= 34; k++) begin
      exp = {k == 0 || k == 32, k == 2 || k == 34, 1'b0, 1'b1,
             exp_to | (k >= 10), exp_fc};
      n_tests++;
      if (obs !== exp) begin n_fail++; $display("FAIL timeout k=%0d got=%h exp=%h", k, obs, exp); end
      imu_done  = (k == 1) || (k == 33) || (k == 5);
      phys_done = 1'b0;
      led_done  = (k == 20);
      @(negedge clk);
    end
    reset = 1'b1; imu_done = 1'b0; phys_done = 1'b1; led_done = 1'b0;
    @(negedge clk);
    n_tests++;
    if (obs !== 21'd0) begin n_fail++; $display("FAIL reset_mid_frame got=%h exp=%h", obs, 21'd0); end
    reset = 1'b0; run = 1'b0; phys_done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      phys_done = 1'b0;
      n_tests++;
      if (obs !== 21'd0) begin n_fail++; $display("FAIL late_done_after_reset k=%0d got=%h exp=%h", k, obs, 21'd0); end
    end
    exp_fc = 16'd0; exp_to = 1'b0;
  endtask

  // Preload the counter near the top, then two step frames wrap it.
  task automatic test_wrap();
    logic [20:0] exp;
    force dut.frame_count = 16'hFFFE;
    @(negedge clk);
    release dut.frame_count;
    exp_fc = 16'hFFFE;
    n_tests++;
    if (obs !== {4'b0, exp_to, exp_fc}) begin
      n_fail++; $display("FAIL wrap_preload got=%h exp=%h", obs, {4'b0, exp_to, exp_fc});
    end
    for (int fr = 0; fr < 2; fr++) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      for (int k = 0; k <= int'(FC); k++) begin
        exp = {k == 0, k == 1, k == 2, k < int'(FC), exp_to,
               (k >= 3) ? 16'(exp_fc + 16'd1) : exp_fc};
        n_tests++;
        if (obs !== exp) begin n_fail++; $display("FAIL wrap fr=%0d k=%0d got=%h exp=%h", fr, k, obs, exp); end
        imu_done = (k == 0); phys_done = (k == 1); led_done = (k == 2);
        @(negedge clk);
      end
      exp_fc = 16'(exp_fc + 16'd1);
    end
    for (int k = 0; k < 5; k++) begin
      imu_done = 1'($urandom_range(1, 0)); phys_done = 1'($urandom_range(1, 0)); led_done = 1'b1;
      @(negedge clk);
      n_tests++;
      if (obs !== {4'b0, exp_to, exp_fc}) begin
        n_fail++; $display("FAIL stray_idle k=%0d got=%h exp=%h", k, obs, {4'b0, exp_to, exp_fc});
      end
    end
    imu_done = 1'b0; phys_done = 1'b0; led_done = 1'b0;
  endtask

  // Free-run frames with random stage latencies (some past the limit) and stray dones.
  task automatic test_free_run();
    int          d[3];
    int          st[4];
    bit          started[3];
    bit          ok;
    int          hold_at, end_k, stop_k, wait_stg, s, lim;
    logic [20:0] exp;
    logic [2:0]  dn;
    run = 1'b1;
    @(negedge clk);
    for (int f = 0; f < NF; f++) begin
      for (int i = 0; i < 3; i++) begin
        d[i] = (f < 2) ? 2 : int'($urandom_range(TO + 1, 1));
        started[i] = 1'b0;
      end
      st[0] = 0; ok = 1'b1; hold_at = 0;
      for (int i = 0; i < 3; i++) begin
        if (ok) begin
          started[i] = 1'b1;
          if (d[i] <= int'(TO)) st[i+1] = st[i] + d[i];
          else begin ok = 1'b0; hold_at = st[i] + int'(TO); end
        end
      end
      if (ok) hold_at = st[3];
      stop_k = (f == NF - 1) ? int'($urandom_range(FC - 2, 1)) : -1;
      end_k  = (hold_at + 1 > int'(FC)) ? hold_at + 1 : int'(FC);
      for (int k = 0; k < end_k; k++) begin
        exp = {k == 0, started[1] && (k == st[1]), started[2] && (k == st[2]), 1'b1,
               exp_to | (!ok && (k >= hold_at)),
               (ok && (k >= hold_at)) ? 16'(exp_fc + 16'd1) : exp_fc};
        n_tests++;
        if (obs !== exp) begin n_fail++; $display("FAIL free_run f=%0d k=%0d got=%h exp=%h", f, k, obs, exp); end
        dn = 3'b000; wait_stg = -1;
        for (int i = 0; i < 3; i++) begin
          lim = (d[i] <= int'(TO)) ? d[i] : int'(TO);
          if (started[i] && (st[i] + d[i] == k + 1)) dn[i] = 1'b1;
          if (started[i] && (k + 1 > st[i]) && (k + 1 <= st[i] + lim)) wait_stg = i;
        end
        if ($urandom_range(3, 0) == 0) begin
          s = int'($urandom_range(2, 0));
          if (s != wait_stg) dn[s] = 1'b1;
        end
        imu_done = dn[0]; phys_done = dn[1]; led_done = dn[2];
        if (k == stop_k) run = 1'b0;
        @(negedge clk);
      end
      if (ok) exp_fc = 16'(exp_fc + 16'd1);
      else exp_to = 1'b1;
    end
    imu_done = 1'b0; phys_done = 1'b0; led_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (obs !== {4'b0, exp_to, exp_fc}) begin
        n_fail++; $display("FAIL run_stop k=%0d got=%h exp=%h", k, obs, {4'b0, exp_to, exp_fc});
      end
      @(negedge clk);
    end
  endtask

  // LED stage returns 40 cycles after its start: HOLD lasts one cycle, then next frame.
  task automatic test_overrun();
    logic [20:0] exp;
    run2 = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= 46; k++) begin
      exp = {k == 0 || k == 45, k == 2, k == 4, 1'b1, 1'b0, (k >= 44) ? 16'd1 : 16'd0};
      n_tests++;
      if (obs2 !== exp) begin n_fail++; $display("FAIL overrun k=%0d got=%h exp=%h", k, obs2, exp); end
      imu_done2 = (k == 1); phys_done2 = (k == 3); led_done2 = (k == 43);
      @(negedge clk);
    end
    run2 = 1'b0; imu_done2 = 1'b0; phys_done2 = 1'b0; led_done2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_step();
    test_timeout_reset();
    test_wrap();
    test_free_run();
    test_overrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
